// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester/transmitter bundle shared by the arbiter and its clients
interface uart_tx_arbiter_if #(
  parameter int WORD_SIZE = 8,
  parameter int NUM_REQ   = 4
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*WORD_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           done;
  logic                         busy;
  logic                         timeout;
  logic [WORD_SIZE-1:0]         tx_data;
  logic                         tx_send;
  logic                         tx_sent_i;
  modport master (
    output req, req_data, tx_sent_i,
    input  grant, done, busy, timeout, tx_data, tx_send
  );
  modport slave (
    input  req, req_data, tx_sent_i,
    output grant, done, busy, timeout, tx_data, tx_send
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter; watchdog built when UART_ARB_TIMEOUT_EN is defined
module uart_tx_arbiter #(
  parameter int WORD_SIZE      = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, ptr_n, cur, cur_n, win;
  logic hit, to, fin;
  logic [NUM_REQ-1:0] grant_n, done_n;
  logic busy_n, timeout_n, tx_send_n;
  logic [WORD_SIZE-1:0] tx_data_n;
  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % NUM_REQ);
  endfunction
  // winner: first set req scanning upward from ptr; reverse loop so the nearest index is assigned last
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req[wrap(int'(ptr) + i)]) begin
        hit = 1'b1;
        win = wrap(int'(ptr) + i);
      end
  end
`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign to = cnt == CW'(TIMEOUT_CYCLES - 1);
  // watchdog: held at zero outside WAIT, counts WAIT cycles; the limit is reached on the edge it would hit TIMEOUT_CYCLES
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= state == WAIT ? cnt + 1'b1 : '0;
`else
  assign to = TIMEOUT_CYCLES < 0;
`endif
  assign fin = state == WAIT && (bus.tx_sent_i || to);
  // state and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cur         <= '0;
      bus.grant   <= '0;
      bus.done    <= '0;
      bus.busy    <= 1'b0;
      bus.timeout <= 1'b0;
      bus.tx_send <= 1'b0;
      bus.tx_data <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      cur         <= cur_n;
      bus.grant   <= grant_n;
      bus.done    <= done_n;
      bus.busy    <= busy_n;
      bus.timeout <= timeout_n;
      bus.tx_send <= tx_send_n;
      bus.tx_data <= tx_data_n;
    end
  // next state: one word outstanding, requests only looked at in IDLE
  always_comb
    state_n = state == IDLE  ? (hit ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              fin ? IDLE : WAIT;
  // next registered outputs; completion beats the watchdog on the same edge
  always_comb begin
    grant_n   = state == IDLE && hit ? NUM_REQ'(1) << win : '0;
    done_n    = state == WAIT && bus.tx_sent_i ? NUM_REQ'(1) << cur : '0;
    timeout_n = state == WAIT && !bus.tx_sent_i && to;
    tx_send_n = state == ISSUE;
    busy_n    = state == IDLE ? hit : state == ISSUE ? 1'b1 : !fin;
    tx_data_n = state == IDLE && hit ? bus.req_data[win*WORD_SIZE +: WORD_SIZE] : bus.tx_data;
    cur_n     = state == IDLE && hit ? win : cur;
    ptr_n     = fin ? wrap(int'(cur) + 1) : ptr;
  end
endmodule
